// File: rtl/artyz7_input_debouncer_pkg.sv
// Shared definitions for the Arty Z7 input debouncer.
//   - dbnc_state_e : per-channel debounce FSM state encoding (2 bits)
//   - clog2        : constant function used to size the qualification counter
// Ports: none (package).
package artyz7_input_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } dbnc_state_e;

  // Minimum 1 so a counter declared with this width is never zero-width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        result = result + 1;
        v = v >> 1;
      end
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/artyz7_debounce_channel.sv
// One debounce channel: SYNC_STAGES-deep synchroniser, debounce FSM with
// qualification counter, registered level and one-cycle rise/fall pulses.
// Ports:
//   clk_ext    in   sole clock
//   rst_ext_n  in   asynchronous active-low reset
//   din        in   raw asynchronous input
//   level      out  debounced level (registered)
//   rise       out  one-cycle pulse on accepted 0->1
//   fall       out  one-cycle pulse on accepted 1->0
module artyz7_debounce_channel
  import artyz7_input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_ext,
  input  logic rst_ext_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  dbnc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk_ext or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_ext or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The counter already holds 1 on entry to WAIT_*, so acceptance happens
  // after DEBOUNCE_CYCLES+1 consecutive samples of the new value. A sample
  // equal to the current level drops straight back with no partial credit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/artyz7_input_debouncer.sv
// Arty Z7 input debouncer top: NUM_CHANNELS independent debounce channels.
// Optional feature macro: ARTYZ7_INPUT_DEBOUNCER_EDGE_COUNT_EN adds
// per-channel saturating rise counters with a synchronous clear.
// Ports:
//   clk_ext       in   sole clock
//   rst_ext_n     in   asynchronous active-low reset
//   led           in   [0:NUM_CHANNELS-1] raw inputs, bit i = channel i
//   dummy_output  out  bit i = debounced level of channel i, upper bits 0
//   rise_pulse    out  one-cycle pulse per channel on accepted 0->1
//   fall_pulse    out  one-cycle pulse per channel on accepted 1->0
//   clear_counts  in   (feature) synchronous clear, wins over increments
//   edge_count    out  (feature) channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
module artyz7_input_debouncer
  import artyz7_input_debouncer_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int OUTPUT_WIDTH    = 22,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                    clk_ext,
  input  logic                    rst_ext_n,
  input  logic [0:NUM_CHANNELS-1] led,
  output logic [OUTPUT_WIDTH-1:0] dummy_output,
  output logic [NUM_CHANNELS-1:0] rise_pulse,
  output logic [NUM_CHANNELS-1:0] fall_pulse
`ifdef ARTYZ7_INPUT_DEBOUNCER_EDGE_COUNT_EN
  ,
  input  logic                                clear_counts,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] edge_count
`endif
);

  // Elaboration-time parameter legality.
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > OUTPUT_WIDTH) begin : g_bad_channels
    $error("NUM_CHANNELS must be in 1..OUTPUT_WIDTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (COUNT_WIDTH < 1) begin : g_bad_count
    $error("COUNT_WIDTH must be >= 1");
  end

  logic [NUM_CHANNELS-1:0] level_vec;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    artyz7_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_ext  (clk_ext),
      .rst_ext_n(rst_ext_n),
      .din      (led[i]),
      .level    (level_vec[i]),
      .rise     (rise_pulse[i]),
      .fall     (fall_pulse[i])
    );
  end

  always_comb begin
    dummy_output = '0;
    dummy_output[NUM_CHANNELS-1:0] = level_vec;
  end

`ifdef ARTYZ7_INPUT_DEBOUNCER_EDGE_COUNT_EN
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_cnt
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk_ext or negedge rst_ext_n) begin
      if (!rst_ext_n) begin
        count_q <= '0;
      end else if (clear_counts) begin
        count_q <= '0;
      end else if (rise_pulse[i] && (count_q != {COUNT_WIDTH{1'b1}})) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end

    assign edge_count[i*COUNT_WIDTH +: COUNT_WIDTH] = count_q;
  end
`endif

endmodule
